// File: rtl/cpu5_alu_pkg.sv
// Shared definitions for the 5-bit CPU ALU: datapath constants and the
// rotate-right sequencer state type.
package cpu5_alu_pkg;

  localparam int CPU_WIDTH   = 5;
  localparam int ALU_SHAMT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ror_state_t;

endpackage

// File: rtl/alu_ror_seq_5bit.sv
// Multi-cycle rotate-right unit: rotates A right by B[SHAMT_W-1:0], one bit
// per clock, with a start/busy/done handshake. R holds until the next done.
// Optional macro ALU_ROR_FLAGS_EN adds registered carry (C) and zero (Z) flags.
module alu_ror_seq_5bit
  import cpu5_alu_pkg::*;
#(
  parameter int WIDTH   = CPU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   R
`ifdef ALU_ROR_FLAGS_EN
  ,
  output logic               C,
  output logic               Z
`endif
);

  ror_state_t          state, state_nxt;
  logic [WIDTH-1:0]    work, work_nxt;
  logic [SHAMT_W-1:0]  cnt, cnt_nxt;
  logic                unused_b;

  // Only the low SHAMT_W bits of B select the rotate amount.
  assign unused_b = ^B[WIDTH-1:SHAMT_W];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (B[SHAMT_W-1:0] != '0) ? SHIFT : DONE;
      SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Next working value and count; the final rotation lands in R on the same
  // edge that enters DONE, so R is taken from work_nxt rather than work.
  always_comb begin
    work_nxt = work;
    cnt_nxt  = cnt;
    unique case (state)
      IDLE: if (start) begin
        work_nxt = A;
        cnt_nxt  = B[SHAMT_W-1:0];
      end
      SHIFT: begin
        work_nxt = {work[0], work[WIDTH-1:1]};
        cnt_nxt  = cnt - SHAMT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      R    <= '0;
    end else begin
      work <= work_nxt;
      cnt  <= cnt_nxt;
      if (state_nxt == DONE) R <= work_nxt;
    end
  end

`ifdef ALU_ROR_FLAGS_EN
  // Flags register alongside R; a zero-amount op goes straight from IDLE to
  // DONE and therefore reports no carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C <= 1'b0;
      Z <= 1'b0;
    end else if (state_nxt == DONE) begin
      C <= (state == SHIFT) ? work_nxt[WIDTH-1] : 1'b0;
      Z <= (work_nxt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_ror_seq_5bit.sv
// Directed bench for alu_ror_seq_5bit: hand-computed results, latency,
// handshake, reset abort and back-to-back operation.
module tb_alu_ror_seq_5bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] A;
  logic [4:0] B;
  logic       busy;
  logic       done;
  logic [4:0] R;
`ifdef ALU_ROR_FLAGS_EN
  logic       C;
  logic       Z;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ror_seq_5bit #(.WIDTH(5), .SHAMT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R)
`ifdef ALU_ROR_FLAGS_EN
    ,
    .C     (C),
    .Z     (Z)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Left rotate by k, used to express the expected right rotate.
  function automatic logic [4:0] rotl(input logic [4:0] a, input int unsigned k);
    logic [4:0] r;
    r = a;
    for (int unsigned i = 0; i < k; i++) r = {r[3:0], r[4]};
    return r;
  endfunction

  // Issue one op from IDLE; returns at the negedge where done is seen,
  // with lat = edges from the accept edge (inclusive) to done.
  task automatic run_op(input logic [4:0] a, input logic [4:0] b, output int lat);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  int lat;
  int ndone;
  logic [4:0] ra;

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_R",    32'(R),    32'd0);
`ifdef ALU_ROR_FLAGS_EN
    check("reset_C", 32'(C), 32'd0);
    check("reset_Z", 32'(Z), 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1) rotate by 1
    @(negedge clk);
    A = 5'b00001; B = 5'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    check("t1_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_in_done", 32'(busy), 32'd0);
    check("t1_R", 32'(R), 32'(5'b10000));
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // 2) rotate by 2, then hold
    run_op(5'b10110, 5'd2, lat);
    check("t2_lat", 32'(lat), 32'd3);
    check("t2_R", 32'(R), 32'(5'b10101));
    repeat (3) @(negedge clk);
    check("t2_hold_R", 32'(R), 32'(5'b10101));
    check("t2_hold_done", 32'(done), 32'd0);

    // 3) upper B bits ignored
    run_op(5'b11001, 5'b11111, lat);
    check("t3_lat", 32'(lat), 32'd4);
    check("t3_R", 32'(R), 32'(5'b00111));
`ifdef ALU_ROR_FLAGS_EN
    check("t3_C", 32'(C), 32'd0);
    check("t3_Z", 32'(Z), 32'd0);
`endif

    // 4) zero amount
    run_op(5'b01010, 5'd0, lat);
    check("t4_lat", 32'(lat), 32'd1);
    check("t4_R", 32'(R), 32'(5'b01010));

`ifdef ALU_ROR_FLAGS_EN
    run_op(5'b10000, 5'd0, lat);
    check("f_C_amt0", 32'(C), 32'd0);
    run_op(5'b00001, 5'd1, lat);
    check("f_C_set", 32'(C), 32'd1);
    check("f_Z_clr", 32'(Z), 32'd0);
    run_op(5'b00000, 5'd2, lat);
    check("f_Z_set", 32'(Z), 32'd1);
    check("f_C_zero", 32'(C), 32'd0);
`endif

    // 4b) second start while busy is ignored
    @(negedge clk);
    @(negedge clk);
    A = 5'b10011; B = 5'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 5'b00000; B = 5'd0;
    ndone = 0;
    @(negedge clk);
    start = 1'b0;
    if (done) ndone++;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t4_one_done", 32'(ndone), 32'd1);
    check("t4_busy_R", 32'(R), 32'(5'b01110));

    // 5) reset during SHIFT
    @(negedge clk);
    A = 5'b11111; B = 5'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_R", 32'(R), 32'd0);
    ndone = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done", 32'(ndone), 32'd0);
    run_op(5'b00110, 5'd1, lat);
    check("t5_after_lat", 32'(lat), 32'd2);
    check("t5_after_R", 32'(R), 32'(5'b00011));

    // start held high: one op per n+2 clocks
    @(negedge clk);
    @(negedge clk);
    A = 5'b00011; B = 5'd1; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check("held_start_dones", 32'(ndone), 32'd4);
    repeat (6) @(negedge clk);

    // 6) random A over every amount
    for (int i = 0; i < 8; i++) begin
      ra = 5'($urandom);
      run_op(ra, 5'(i % 4), lat);
      check("rand_lat", 32'(lat), 32'(i % 4 + 1));
      check("rand_R", 32'(R), 32'(rotl(ra, (5 - (i % 4)) % 5)));
`ifdef ALU_ROR_FLAGS_EN
      check("rand_Z", 32'(Z), 32'(R == 5'd0));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1);
  end

endmodule
